serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial adder controller that sits directly in front of the full_adder slice.
//   Latches two WIDTH-bit operands and drives the slice one bit per clock, LSB first:
//   X/Y bits, plus the registered carry into Cprev.
//   Collects RES into a sum shift register and feeds Cnext back through a carry flip-flop.
//   Gives the toy processor a multi-bit add from one combinational full-adder cell.
// PARAMETERS
//   WIDTH    4  operand/sum width in bits (min 2)
//   CNT_W    3  bit-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   CLK       in   1      rising-edge clock
//   RST       in   1      synchronous active-high reset
//   START     in   1      request; sampled only in IDLE
//   A         in   WIDTH  operand A, latched on accepted START
//   B         in   WIDTH  operand B, latched on accepted START
//   CIN       in   1      carry-in, latched on accepted START
//   FA_X      out  1      to full_adder X: current A bit
//   FA_Y      out  1      to full_adder Y: current B bit
//   FA_CPREV  out  1      to full_adder Cprev: carry flip-flop
//   FA_RES    in   1      from full_adder RES
//   FA_CNEXT  in   1      from full_adder Cnext
//   BUSY      out  1      high in RUN and DONE
//   DONE      out  1      one-cycle pulse: SUM/COUT/OVF valid
//   SUM       out  WIDTH  result, held until next accepted START
//   COUT      out  1      carry out of MSB, held with SUM
//   OVF       out  1      signed overflow (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=IDLE; count, a_sh, b_sh, carry, SUM, COUT, OVF, DONE, BUSY all 0.
//     Applies in any state; an add in progress is abandoned with no DONE.
//   FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE
//     FA_X/FA_Y/FA_CPREV driven 0.
//     On START=1: load a_sh=A, b_sh=B, carry=CIN, clear SUM, count=0; go to RUN.
//   RUN
//     FA_X=a_sh[0], FA_Y=b_sh[0], FA_CPREV=carry (all registered, no comb path from inputs).
//     Each edge: SUM <= {FA_RES, SUM[WIDTH-1:1]}; carry <= FA_CNEXT.
//     Also each edge: a_sh/b_sh shift right, 0 fill; count++.
//     Edge where count==WIDTH-1 (last bit): COUT <= FA_CNEXT; go to DONE.
//   DONE: DONE=1 for exactly one cycle; unconditionally go to IDLE next edge.
//   Latency: START sampled at edge 0; DONE high in the cycle after edge WIDTH.
//     Throughput: one add per WIDTH+2 cycles.
//   Arithmetic: {COUT,SUM} == A+B+CIN, unsigned, WIDTH+1 bits.
//   START while BUSY=1 is ignored, including in the DONE cycle; no queuing.
//     START held high in IDLE begins a new add.
//   Operand changes after the accepted START have no effect on the result.
//   SUM/COUT/OVF are not updated from RUN until the final edge, except SUM shifting.
//     Consumers sample only on DONE.
// CONFIGURATION
//   SERIAL_ADD_OVF_EN defined
//     At the RUN edge with count==WIDTH-1, capture c_msb = carry (the carry into the MSB).
//     On the same edge: OVF <= c_msb ^ FA_CNEXT.
//     OVF is valid with DONE and held with SUM; cleared on reset and on accepted START.
//   SERIAL_ADD_OVF_EN undefined: c_msb logic absent; OVF tied to 0.
// TESTING (WIDTH=4, OVF_EN defined unless noted)
//   A=3,B=5,CIN=0
//     -> DONE after edge 4 post-START; SUM=8, COUT=0, OVF=1.
//     FA_X sequence 1,1,0,0.
//   A=15,B=1,CIN=0 -> SUM=0, COUT=1, OVF=0.
//   A=7,B=7,CIN=1 -> SUM=15, COUT=0, OVF=1.
//     Rebuild without macro -> OVF=0.
//   START pulsed during RUN and DONE of add A=2,B=2
//     -> exactly one DONE, SUM=4, no second add.
//   RST=1 at RUN count==2 -> next cycle IDLE, DONE never pulses, SUM=0, BUSY=0.
//   Exhaustive: all A,B in 0..15, CIN in {0,1}, back-to-back STARTs
//     -> {COUT,SUM}==A+B+CIN for every case.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller for a single full_adder cell.
// Latches A/B/CIN on an accepted START, feeds the cell one bit per clock
// (LSB first), shifts RES into SUM and loops Cnext back through a carry flop.
// Optional feature macro: SERIAL_ADD_OVF_EN (signed overflow on OVF; when
// undefined OVF is tied to 0).
// Handshake: START is a request sampled only in IDLE; BUSY is high from the
// edge that accepts it until the controller returns to IDLE; DONE is a
// one-cycle pulse during which SUM/COUT/OVF are valid (and they stay held
// until the next accepted START).
module serial_adder_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             FA_X,
  output logic             FA_Y,
  output logic             FA_CPREV,
  input  logic             FA_RES,
  input  logic             FA_CNEXT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic             start_acc;
  logic             last_bit;

  assign start_acc = (state == S_IDLE) && START;
  assign last_bit  = (state == S_RUN) && (count == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_RUN;
      S_RUN:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand shifters, carry flop, bit counter and result capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count  <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (start_acc) begin
      a_sh  <= A;
      b_sh  <= B;
      carry <= CIN;
      sum_r <= '0;
      count <= '0;
    end else if (state == S_RUN) begin
      sum_r <= {FA_RES, sum_r[WIDTH-1:1]};
      carry <= FA_CNEXT;
      a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      count <= count + CNT_W'(1);
      if (last_bit) cout_r <= FA_CNEXT;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic c_msb;
  logic ovf_r;

  // On the MSB step the carry flop holds the carry into the MSB.
  assign c_msb = carry;

  // Signed overflow: carry into MSB differs from carry out of MSB.
  always_ff @(posedge CLK) begin
    if (RST)            ovf_r <= 1'b0;
    else if (start_acc) ovf_r <= 1'b0;
    else if (last_bit)  ovf_r <= c_msb ^ FA_CNEXT;
  end

  assign OVF = ovf_r;
`else
  assign OVF = 1'b0;
`endif

  // Slice drive is purely registered; forced low outside RUN.
  assign FA_X      = (state == S_RUN) && a_sh[0];
  assign FA_Y      = (state == S_RUN) && b_sh[0];
  assign FA_CPREV  = (state == S_RUN) && carry;
  assign BUSY      = (state != S_IDLE);
  assign DONE      = (state == S_DONE);
  assign SUM       = sum_r;
  assign COUT      = cout_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl (WIDTH=4).
// The full_adder cell is modelled combinationally here.
module tb_serial_adder_ctrl;

  localparam int W = 4;
`ifdef SERIAL_ADD_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         fa_x, fa_y, fa_cprev, fa_res, fa_cnext;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int push_cnt = 0;

  // expected entry: {ovf, cout, sum}
  logic [W+1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // full_adder cell model
  assign fa_res   = fa_x ^ fa_y ^ fa_cprev;
  assign fa_cnext = (fa_x & fa_y) | (fa_x & fa_cprev) | (fa_y & fa_cprev);

  serial_adder_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
    .CLK(clk), .RST(rst), .START(start), .A(a), .B(b), .CIN(cin),
    .FA_X(fa_x), .FA_Y(fa_y), .FA_CPREV(fa_cprev),
    .FA_RES(fa_res), .FA_CNEXT(fa_cnext),
    .BUSY(busy), .DONE(done), .SUM(sum), .COUT(cout), .OVF(ovf),
    .state_dbg(state_dbg)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && done) begin
      logic [W+1:0] e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got sum=%0d cout=%0d with empty queue", sum, cout);
      end else begin
        e = exp_q.pop_front();
        check("result{ovf,cout,sum}", int'({ovf, cout, sum}), int'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // Issue one add; expected result supplied by caller.
  task automatic do_add(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    wait_idle();
    a = ai; b = bi; cin = ci; start = 1'b1;
    exp_q.push_back({eo & OVF_ON, ec, es});
    push_cnt++;
    @(negedge clk);
    start = 1'b0;
    // operands after acceptance must not matter
    a = W'($urandom_range(0, 15));
    b = W'($urandom_range(0, 15));
    cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int s, cm, co;
    logic [3:0] xs;

    // reset
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_state", state_dbg, 0);
    check("rst_fa_xyc", {fa_x, fa_y, fa_cprev}, 0);
    rst = 1'b0;
    @(negedge clk);

    // A=3,B=5: latency and FA_X sequence, checked inline
    a = 4'd3; b = 4'd5; cin = 1'b0; start = 1'b1;
    exp_q.push_back({OVF_ON, 1'b0, 4'd8});
    push_cnt++;
    xs = '0;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n <= 4) xs[n-1] = fa_x;
    end while (!done && n < 20);
    check("latency_negedges", n, 5);
    check("fa_x_seq_lsb_first", xs, 4'b0011);

    // directed vectors, hand-computed
    do_add(4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0);
    do_add(4'd7,  4'd7, 1'b1, 4'd15, 1'b0, 1'b1);
    do_add(4'd8,  4'd8, 1'b0, 4'd0,  1'b1, 1'b1);
    do_add(4'd0,  4'd0, 1'b1, 4'd1,  1'b0, 1'b0);
    do_add(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);
    wait_drain();

    // START pulsed during RUN and DONE: only one add
    wait_idle();
    n = done_cnt;
    a = 4'd2; b = 4'd2; cin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 4'd4});
    push_cnt++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = (k == 2 || k == 5);   // k==5 lands in the DONE cycle
    end
    @(negedge clk);
    start = 1'b0;
    check("no_restart_busy", busy, 0);
    repeat (8) @(negedge clk);
    check("single_done_count", done_cnt - n, 1);
    check("no_restart_busy_later", busy, 0);

    // reset mid-RUN at count==2: abandoned, no DONE
    wait_idle();
    n = done_cnt;
    a = 4'd9; b = 4'd3; cin = 1'b1; start = 1'b1;
    @(negedge clk);  // after edge 0, count=0
    start = 1'b0;
    @(negedge clk);  // count=1
    @(negedge clk);  // count=2
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_sum", sum, 0);
    repeat (8) @(negedge clk);
    check("mid_rst_no_done", done_cnt - n, 0);

    // exhaustive back-to-back
    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++) begin
          s  = ai + bi + ci;
          cm = ((ai & 7) + (bi & 7) + ci) >> 3;
          co = s >> 4;
          do_add(W'(ai), W'(bi), 1'(ci), W'(s), 1'(co), 1'(cm ^ co));
        end
    wait_drain();
    check("total_done_count", done_cnt, push_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time guard
  initial begin
    #1000000;
    errors++;
    $display("FAIL global_timeout: got no completion expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
